dpr_bist_ctrl: RTL



---
 rtl/dpr_bist_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dpr_bist_ctrl.sv
// BIST controller for the true dual-port RAM: writes a seeded address pattern through
// each port, reads it back through the other, and reports the first mismatch.
module dpr_bist_ctrl #(
    parameter int unsigned       ADDR_W = 12,
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5,
    parameter int unsigned       RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_phase,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              wr_en_0,
    output logic [ADDR_W-1:0] addr_0,
    output logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] out_0,
    output logic              wr_en_1,
    output logic [ADDR_W-1:0] addr_1,
    output logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] out_1
);
    localparam int unsigned       DRW    = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] A_LAST = '1;

    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

    state_t            state;
    logic              issue;
    logic [DRW-1:0]    drain;
    logic              pv [RD_LAT];
    logic [ADDR_W-1:0] pa [RD_LAT];
    logic [DATA_W-1:0] pe [RD_LAT];

    logic              mism;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_exp;
    logic [ADDR_W-1:0] a0_inc, a0_dec, a1_inc, a1_dec;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED;
    endfunction

    // Read-side selection and compare at the tail of the latency pipeline
    always_comb begin
        rd_data = (state == RD1) ? out_0 : out_1;
        rd_addr = (state == RD1) ? addr_0 : addr_1;
        rd_exp  = (state == RD1) ? ~pat(addr_0) : pat(addr_1);
        mism    = ((state == RD0) || (state == RD1)) && pv[RD_LAT-1]
                  && (rd_data != pe[RD_LAT-1]);
        a0_inc  = addr_0 + ADDR_W'(1);
        a0_dec  = addr_0 - ADDR_W'(1);
        a1_inc  = addr_1 + ADDR_W'(1);
        a1_dec  = addr_1 - ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue      <= 1'b0;
            drain      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_phase <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
            wr_en_0    <= 1'b0;
            addr_0     <= '0;
            in_0       <= '0;
            wr_en_1    <= 1'b0;
            addr_1     <= '0;
            in_1       <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
                pe[i] <= '0;
            end
        end else begin
            // Each issued read carries its address and expected data RD_LAT cycles forward
            pv[0] <= issue;
            pa[0] <= rd_addr;
            pe[0] <= rd_exp;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pe[i] <= pe[i-1];
            end

            if (mism) begin
                state      <= DONE;
                busy       <= 1'b0;
                done       <= 1'b1;
                pass       <= 1'b0;
                fail_phase <= (state == RD1) ? 2'd3 : 2'd1;
                fail_addr  <= pa[RD_LAT-1];
                fail_data  <= rd_data;
                wr_en_0    <= 1'b0;
                wr_en_1    <= 1'b0;
                issue      <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state      <= WR0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            pass       <= 1'b0;
                            fail_phase <= '0;
                            fail_addr  <= '0;
                            fail_data  <= '0;
                            wr_en_0    <= 1'b1;
                            addr_0     <= '0;
                            in_0       <= pat('0);
                            wr_en_1    <= 1'b0;
                            issue      <= 1'b0;
                            drain      <= '0;
                            for (int i = 0; i < int'(RD_LAT); i++) pv[i] <= 1'b0;
                        end
                    end
                    WR0: begin
                        if (addr_0 == A_LAST) begin
                            state   <= RD0;
                            wr_en_0 <= 1'b0;
                            addr_1  <= '0;
                            issue   <= 1'b1;
                        end else begin
                            addr_0 <= a0_inc;
                            in_0   <= pat(a0_inc);
                        end
                    end
                    RD0: begin
                        if (issue) begin
                            if (addr_1 == A_LAST) begin
                                issue <= 1'b0;
                                drain <= DRW'(RD_LAT);
                            end else begin
                                addr_1 <= a1_inc;
                            end
                        end else if (drain == DRW'(1)) begin
                            state   <= WR1;
                            wr_en_1 <= 1'b1;
                            addr_1  <= A_LAST;
                            in_1    <= ~pat(A_LAST);
                        end else begin
                            drain <= drain - DRW'(1);
                        end
                    end
                    WR1: begin
                        if (addr_1 == '0) begin
                            state   <= RD1;
                            wr_en_1 <= 1'b0;
                            addr_0  <= A_LAST;
                            issue   <= 1'b1;
                        end else begin
                            addr_1 <= a1_dec;
                            in_1   <= ~pat(a1_dec);
                        end
                    end
                    RD1: begin
                        if (issue) begin
                            if (addr_0 == '0) begin
                                issue <= 1'b0;
                                drain <= DRW'(RD_LAT);
                            end else begin
                                addr_0 <= a0_dec;
                            end
                        end else if (drain == DRW'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            drain <= drain - DRW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
